// File: rtl/pkt_wr_sched.sv
// Packet write scheduler: queues capture descriptors, allocates host ring space
// against the host read offset and runs one wr_ctrl transfer per packet.
module pkt_wr_sched #(
  parameter logic [31:0] RING_BASE  = 32'h1000_0000,
  parameter logic [31:0] RING_BYTES = 32'h0000_1000,
  parameter int          MAX_LEN    = 1518,
  parameter int          DESC_DEPTH = 8,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        desc_valid,
  input  logic [15:0] desc_len,
  output logic        desc_ready,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] control,
  input  logic [31:0] host_rd_off,
  output logic [31:0] wr_off,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic        timeout_err,
  output logic        busy
);

  localparam int          QW        = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam logic [QW:0] Q_FULL    = (QW+1)'(DESC_DEPTH);
  localparam logic [31:0] RING_MASK = RING_BYTES - 32'd1;
  localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC,
    S_LAUNCH,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t state_reg, state_next;

  // ---------------- descriptor queue ----------------
  logic [15:0]   q_mem [DESC_DEPTH];
  logic [QW-1:0] q_wr_ptr_reg, q_rd_ptr_reg;
  logic [QW:0]   q_count_reg, q_count_next;
  logic          desc_ready_reg;
  logic          q_push, q_pop, q_empty;
  logic [15:0]   head_len;

  assign q_push   = desc_valid & desc_ready_reg;
  assign q_pop    = (state_reg == S_ALLOC);
  assign q_empty  = (q_count_reg == '0);
  assign head_len = q_mem[q_rd_ptr_reg];

  always_comb begin
    q_count_next = q_count_reg;
    case ({q_push, q_pop})
      2'b10:   q_count_next = q_count_reg + (QW+1)'(1);
      2'b01:   q_count_next = q_count_reg - (QW+1)'(1);
      default: q_count_next = q_count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_mem[q_wr_ptr_reg] <= desc_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_wr_ptr_reg   <= '0;
      q_rd_ptr_reg   <= '0;
      q_count_reg    <= '0;
      desc_ready_reg <= 1'b1;
    end else begin
      if (q_push) q_wr_ptr_reg <= q_wr_ptr_reg + QW'(1);
      if (q_pop)  q_rd_ptr_reg <= q_rd_ptr_reg + QW'(1);
      q_count_reg    <= q_count_next;
      desc_ready_reg <= (q_count_next != Q_FULL);
    end
  end

  // ---------------- allocation checks on the queue head ----------------
  logic [31:0] wr_off_reg;
  logic [31:0] alloc_len, alloc_start, alloc_pad, alloc_used, alloc_need;
  logic        alloc_wrap, alloc_bad, alloc_full;

  assign alloc_len   = {16'h0, head_len};
  assign alloc_bad   = (head_len == 16'h0) || (head_len[1:0] != 2'b00) || (alloc_len > MAX_LEN_W);
  assign alloc_wrap  = (wr_off_reg + alloc_len) > RING_BYTES;
  assign alloc_start = alloc_wrap ? 32'h0 : wr_off_reg;
  assign alloc_pad   = alloc_wrap ? (RING_BYTES - wr_off_reg) : 32'h0;
  assign alloc_used  = (wr_off_reg - host_rd_off) & RING_MASK;
  // len+pad > RING_BYTES-used-4, rearranged so a bogus host offset cannot underflow
  assign alloc_need  = alloc_len + alloc_pad + alloc_used + 32'd4;
  assign alloc_full  = alloc_need > RING_BYTES;

  // ---------------- control FSM ----------------
  logic [31:0] tcnt_reg;
  logic        alloc_go, alloc_drop, wait_expire;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    alloc_go    = 1'b0;
    alloc_drop  = 1'b0;
    wait_expire = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!q_empty && enable) state_next = S_ALLOC;
      end
      S_ALLOC: begin
        if (alloc_bad || alloc_full) begin
          alloc_drop = 1'b1;
          state_next = S_IDLE;
        end else begin
          alloc_go   = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        if (wr_ctrl_rdy) begin
          state_next = S_COMMIT;
        end else if (tcnt_reg == TO_LAST) begin
          wait_expire = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath and statistics ----------------
  logic [31:0] start_reg, len_reg;
  logic [31:0] pkt_begin_reg, pkt_end_reg, control_reg;
  logic [31:0] pkt_count_reg, drop_count_reg;
  logic [15:0] seq_reg;
  logic        timeout_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_reg       <= '0;
      len_reg         <= '0;
      pkt_begin_reg   <= '0;
      pkt_end_reg     <= '0;
      control_reg     <= '0;
      wr_off_reg      <= '0;
      pkt_count_reg   <= '0;
      drop_count_reg  <= '0;
      seq_reg         <= '0;
      timeout_err_reg <= 1'b0;
      tcnt_reg        <= '0;
    end else begin
      if (alloc_go) begin
        start_reg     <= alloc_start;
        len_reg       <= alloc_len;
        pkt_begin_reg <= RING_BASE + alloc_start;
        pkt_end_reg   <= RING_BASE + alloc_start + alloc_len;
        control_reg   <= {16'h0, seq_reg};
      end
      if (alloc_drop) begin
        drop_count_reg <= drop_count_reg + 32'd1;
      end
      if (state_reg == S_LAUNCH) begin
        tcnt_reg <= '0;
      end else if (state_reg == S_WAIT) begin
        tcnt_reg <= tcnt_reg + 32'd1;
      end
      if (wait_expire) begin
        timeout_err_reg <= 1'b1;
      end
      if (state_reg == S_COMMIT) begin
        wr_off_reg    <= (start_reg + len_reg) & RING_MASK;
        pkt_count_reg <= pkt_count_reg + 32'd1;
        seq_reg       <= seq_reg + 16'd1;
      end
    end
  end

  assign desc_ready  = desc_ready_reg;
  assign wr_ctrl     = (state_reg == S_LAUNCH);
  assign pkt_begin   = pkt_begin_reg;
  assign pkt_end     = pkt_end_reg;
  assign control     = control_reg;
  assign wr_off      = wr_off_reg;
  assign pkt_count   = pkt_count_reg;
  assign drop_count  = drop_count_reg;
  assign timeout_err = timeout_err_reg;
  assign busy        = (state_reg != S_IDLE) || !q_empty;

endmodule
